// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with locked transfers and bounded burst tenure.
// Grant moves at HREADY-high edges; HMASTER/HMASTLOCK follow the grant one HREADY edge later.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 8
) (
  input  logic                   in_HCLK,
  input  logic                   in_HRESETn,
  input  logic [NUM_MASTERS-1:0] in_HBUSREQ,
  input  logic [NUM_MASTERS-1:0] in_HLOCK,
  input  logic [1:0]             in_HTRANS,
  input  logic                   in_HREADY,
  output logic [NUM_MASTERS-1:0] out_HGRANT,
  output logic [1:0]             out_HMASTER,
  output logic                   out_HMASTLOCK
);
  localparam logic [1:0] DEF  = 2'(DEFAULT_MASTER);
  localparam logic [7:0] MAXB = 8'(MAX_BEATS);
  typedef enum logic {FREE, HELD} state_t;
  state_t state_q, state_d;
  logic [1:0] g_q, g_d, win, idx;
  logic [7:0] bc_q;
  logic [3:0] req, lock, gmask;
  logic found, open, rearb, beat;
  assign req   = 4'(in_HBUSREQ);
  assign lock  = 4'(in_HLOCK);
  assign gmask = 4'b1 << g_q;
  assign beat  = in_HTRANS inside {2'b10, 2'b11};
  // first requester after the current grant, wrapping back to it last
  always_comb begin
    win = DEF;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = 2'((int'(g_q) + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // the burst bound only applies once the granted master actually owns the bus
  always_comb begin
    open    = state_q == FREE || !(req[g_q] && lock[g_q]);
    rearb   = open && (!req[g_q] || (bc_q == MAXB && g_q == out_HMASTER && |(req & ~gmask)));
    g_d     = in_HREADY && rearb ? win : g_q;
    state_d = !in_HREADY ? state_q : !open ? HELD : (req[g_d] && lock[g_d]) ? HELD : FREE;
  end
  always_ff @(posedge in_HCLK or negedge in_HRESETn) begin
    if (!in_HRESETn) begin
      state_q       <= FREE;
      g_q           <= DEF;
      out_HGRANT    <= NUM_MASTERS'(4'b1 << DEF);
      out_HMASTER   <= DEF;
      out_HMASTLOCK <= 1'b0;
      bc_q          <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      out_HGRANT <= NUM_MASTERS'(4'b1 << g_d);
      if (in_HREADY) begin
        out_HMASTER   <= g_q;
        out_HMASTLOCK <= req[g_q] & lock[g_q];
        bc_q          <= g_q != out_HMASTER ? '0 : (beat && bc_q != MAXB) ? bc_q + 8'd1 : bc_q;
      end
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_ahb_bus_arbiter;
  localparam int N = 3, DEF = 0, MAXB = 8;
  logic clk = 0, rst_n = 0;
  logic [2:0] req = 0, lock = 0;
  logic [1:0] htrans = 0;
  logic hready = 1;
  logic [2:0] grant;
  logic [1:0] master;
  logic mlock;
  int checks = 0, errors = 0;
  int mg, mo, mbc;
  bit ml, mheld;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MAX_BEATS(MAXB)) dut (
    .in_HCLK(clk), .in_HRESETn(rst_n), .in_HBUSREQ(req), .in_HLOCK(lock),
    .in_HTRANS(htrans), .in_HREADY(hready),
    .out_HGRANT(grant), .out_HMASTER(master), .out_HMASTLOCK(mlock));

  function automatic bit bit_at(logic [3:0] v, int i);
    return v[2'(i)];
  endfunction

  function automatic int scan(int g, logic [2:0] r);
    for (int k = 1; k <= N; k++) if (bit_at(r, (g + k) % N)) return (g + k) % N;
    return DEF;
  endfunction

  task automatic model_reset();
    mg = DEF; mo = DEF; ml = 0; mheld = 0; mbc = 0;
  endtask

  // advance the reference by one clock edge using the inputs currently driven
  task automatic step();
    int ng, nbc;
    bit fr, nh;
    if (hready) begin
      fr = !mheld || !(bit_at(req, mg) && bit_at(lock, mg));
      ng = mg;
      if (fr && (!bit_at(req, mg) || (mbc == MAXB && mo == mg && (req & ~(3'b1 << mg)) != 0)))
        ng = scan(mg, req);
      nh = fr ? (bit_at(req, ng) && bit_at(lock, ng)) : 1'b1;
      nbc = (mo != mg) ? 0 : (htrans[1] && mbc < MAXB) ? mbc + 1 : mbc;
      ml = bit_at(req, mg) && bit_at(lock, mg);
      mo = mg; mg = ng; mheld = nh; mbc = nbc;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1;
    checks++;
    if ({grant, master, mlock} !== {3'b001, 2'd0, 1'b0}) begin
      errors++; $display("FAIL reset_vals got g=%b m=%0d l=%b exp g=001 m=0 l=0", grant, master, mlock);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({grant, master, mlock} !== {3'b001, 2'd0, 1'b0} || {grant, master, mlock} !== {3'(1 << mg), 2'(mo), ml}) begin
        errors++; $display("FAIL reset_idle cyc=%0d got g=%b m=%0d l=%b exp g=001 m=0 l=0", i, grant, master, mlock);
      end
    end
  endtask

  task automatic test_handover();
    req = 3'b010; hready = 1; htrans = 0;
    step();
    checks++;
    if (grant !== 3'b010 || master !== 2'd0) begin
      errors++; $display("FAIL handover_grant got g=%b m=%0d exp g=010 m=0", grant, master);
    end
    step();
    checks++;
    if (grant !== 3'b010 || master !== 2'd1) begin
      errors++; $display("FAIL handover_owner got g=%b m=%0d exp g=010 m=1", grant, master);
    end
  endtask

  task automatic test_wait_states();
    hready = 0; req = 3'b100;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (grant !== 3'b010 || master !== 2'd1) begin
        errors++; $display("FAIL wait_hold cyc=%0d got g=%b m=%0d exp g=010 m=1", i, grant, master);
      end
    end
    hready = 1;
    step();
    checks++;
    if (grant !== 3'b100 || master !== 2'd1) begin
      errors++; $display("FAIL wait_release got g=%b m=%0d exp g=100 m=1", grant, master);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int prev, cnt1;
    req = 3'b001; lock = 0; htrans = 0;
    repeat (3) step();
    checks++;
    if (grant !== 3'b001 || master !== 2'd0) begin
      errors++; $display("FAIL rr_setup got g=%b m=%0d exp g=001 m=0", grant, master);
    end
    req = 3'b111; htrans = 2'b10;
    prev = master; cnt1 = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      htrans = 2'b11;
      checks++;
      if ({grant, master, mlock} !== {3'(1 << mg), 2'(mo), ml}) begin
        errors++; $display("FAIL rr_model cyc=%0d got g=%b m=%0d l=%b exp g=%b m=%0d l=%b", i, grant, master, mlock, 3'(1 << mg), mo, ml);
      end
      if (int'(master) != prev) order.push_back(int'(master));
      prev = master;
      if (master == 2'd1) cnt1++;
    end
    checks++;
    if (order.size() < 3 || order[0] != 1 || order[1] != 2 || order[2] != 0) begin
      errors++; $display("FAIL rr_order got %p exp '{1,2,0}", order);
    end
    checks++;
    if (cnt1 != MAXB + 2) begin
      errors++; $display("FAIL rr_tenure got %0d cycles exp %0d", cnt1, MAXB + 2);
    end
  endtask

  task automatic test_lock();
    req = 3'b100; lock = 3'b100; htrans = 2'b10;
    repeat (2) step();
    req = 3'b101; htrans = 2'b11;
    for (int i = 0; i < 25; i++) begin
      step();
      checks++;
      if (grant !== 3'b100 || master !== 2'd2 || mlock !== 1'b1 || {grant, master, mlock} !== {3'(1 << mg), 2'(mo), ml}) begin
        errors++; $display("FAIL lock_hold cyc=%0d got g=%b m=%0d l=%b exp g=100 m=2 l=1", i, grant, master, mlock);
      end
    end
    lock = 0;
    step();
    checks++;
    if (grant !== 3'b001 || grant !== 3'(1 << mg)) begin
      errors++; $display("FAIL lock_release got g=%b exp g=001", grant);
    end
  endtask

  task automatic test_async_reset();
    req = 3'b010; lock = 0; htrans = 2'b10; hready = 1;
    repeat (3) step();
    checks++;
    if (master !== 2'd1) begin
      errors++; $display("FAIL areset_setup got m=%0d exp m=1", master);
    end
    #3 rst_n = 0;
    #1;
    checks++;
    if ({grant, master, mlock} !== {3'b001, 2'd0, 1'b0}) begin
      errors++; $display("FAIL areset_now got g=%b m=%0d l=%b exp g=001 m=0 l=0", grant, master, mlock);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    req = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req = 3'($urandom);
      lock = 3'($urandom & $urandom);
      htrans = 2'($urandom);
      hready = $urandom_range(0, 3) != 0;
      step();
      checks++;
      if ({grant, master, mlock} !== {3'(1 << mg), 2'(mo), ml} || master > 2'(N - 1)) begin
        errors++; $display("FAIL random cyc=%0d got g=%b m=%0d l=%b exp g=%b m=%0d l=%b", i, grant, master, mlock, 3'(1 << mg), mo, ml);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_handover();
    test_wait_states();
    test_round_robin();
    test_lock();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB bus arbiter that shares the single AHB address/data bus between up to four masters (CPU, Accelerator DMA, debug/test master).
- Drives the per-master HGRANT lines, the registered HMASTER index that steers the master-to-slave address/control mux, and HMASTLOCK.
- Takes the muxed in_HREADY from the slave-to-master response mux and the muxed in_HTRANS of the current bus owner.
- Enforces locked transfers and a bounded burst tenure so no master starves.

Parameters:
- NUM_MASTERS, 3, number of requesting masters; legal range 2..4.
- DEFAULT_MASTER, 0, index granted when no master requests; also the reset owner.
- MAX_BEATS, 8, maximum NONSEQ/SEQ data beats per tenure before forced re-arbitration when another master is waiting; legal range 1..255.

Ports:
- in_HCLK  input  1  AHB clock; all state updates on rising edge.
- in_HRESETn  input  1  asynchronous, active-low reset.
- in_HBUSREQ  input  NUM_MASTERS  bus request, one bit per master.
- in_HLOCK  input  NUM_MASTERS  locked-transfer request, one bit per master; only meaningful with the matching HBUSREQ bit.
- in_HTRANS  input  2  HTRANS of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- in_HREADY  input  1  muxed bus HREADY from the slave response mux.
- out_HGRANT  output  NUM_MASTERS  one-hot grant, registered.
- out_HMASTER  output  2  index of the address-phase owner, registered.
- out_HMASTLOCK  output  1  lock qualifier for the current address phase, registered.

Behaviour:
- Reset (in_HRESETn=0, asynchronous; overrides everything, including a mid-burst reset):
  - out_HGRANT = one-hot(DEFAULT_MASTER); out_HMASTER = DEFAULT_MASTER; out_HMASTLOCK = 0.
  - Beat counter = 0; round-robin pointer = DEFAULT_MASTER.
- State registers: grant index G (drives out_HGRANT), owner index O (drives out_HMASTER), lock flag, beat counter BC (8 bits, saturating at MAX_BEATS).
- State machine, 2 states:
  - FREE: G may change at any HREADY-high edge.
  - HELD: G frozen. Entered when the granted master's HLOCK=1 and HBUSREQ=1 at the edge its grant is registered. Left when that master deasserts HBUSREQ or HLOCK, with in_HREADY=1.
- Re-arbitration point, evaluated on an edge where in_HREADY=1 and state is FREE. Re-arbitration occurs if any of:
  - (a) HBUSREQ[G]=0.
  - (b) BC=MAX_BEATS and some other HBUSREQ bit is set.
- Winner selection:
  - First requester found scanning indices G+1, G+2, ..., wrapping modulo NUM_MASTERS, ending at G.
  - If no bits are set, the winner is DEFAULT_MASTER.
  - If G is the only requester, G is kept.
- Grant-to-owner handover, 1-cycle latency:
  - out_HGRANT updates at the re-arbitration edge.
  - On the next edge with in_HREADY=1: out_HMASTER <= G and out_HMASTLOCK <= HLOCK[G] & HBUSREQ[G].
  - While in_HREADY=0, out_HGRANT, out_HMASTER and out_HMASTLOCK all hold (wait states never move ownership).
- Beat counter:
  - Increments when in_HREADY=1 and in_HTRANS is NONSEQ or SEQ; saturates at MAX_BEATS.
  - Cleared to 0 on the edge out_HMASTER changes value.
  - IDLE and BUSY beats do not count.
- Simultaneous events:
  - Locking overrides MAX_BEATS: BC saturating in HELD causes no handover.
  - A request and a release by the owner in the same cycle are resolved by the round-robin scan from G+1.
- Out-of-range masters: bits of in_HBUSREQ/in_HLOCK at index >= NUM_MASTERS do not exist; out_HMASTER never exceeds NUM_MASTERS-1.

Test Plan:
- Reset: hold in_HRESETn=0, then release with no requests -> out_HGRANT=3'b001, out_HMASTER=0, out_HMASTLOCK=0; unchanged for 10 cycles.
- Simple handover: HBUSREQ=3'b010, in_HREADY=1 -> out_HGRANT=3'b010 after 1 edge, out_HMASTER=1 after 2 edges.
- Wait states: HBUSREQ switches 3'b010->3'b100 while in_HREADY=0 for 3 cycles -> no grant or owner change until the first HREADY-high edge, then out_HGRANT=3'b100.
- Round robin and burst bound: MAX_BEATS=8, HBUSREQ=3'b111, master 0 issues NONSEQ followed by SEQ beats with HREADY=1 -> handover to master 1 after 8 beats, then to master 2 after 8 beats, then back to 0; BC resets each time.
- Lock: master 2 requests with HLOCK=1 while master 0 also requests -> master 2 keeps the grant past 20 beats, out_HMASTLOCK=1; on HLOCK=0 with HREADY=1, the grant moves to master 0.
- Async reset mid-burst: assert in_HRESETn=0 between clock edges while master 1 owns the bus -> outputs return immediately to the reset values listed under Behaviour, without waiting for a clock edge.
